// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// State encoding, grant identifiers and the default abort timeout.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic GNT_INSTR = 1'b0;
   localparam logic GNT_DATA  = 1'b1;

   localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/REG_DRE_32.sv
// Enable register cell with synchronous active-high reset to zero.
// Holds its value whenever EN is low.
module REG_DRE_32 #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RES,
   input  logic             EN,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
);

   always_ff @(posedge CLK) begin
      if (RES)
         Q <= '0;
      else if (EN)
         Q <= D;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-ported memory arbiter for the fetch and load/store ports.
// Define MEM_TIMEOUT_EN to abort busy accesses after TIMEOUT cycles.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADR_W   = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              CLK,
   input  logic              RES,
   input  logic              instr_req,
   input  logic [ADR_W-1:0]  instr_adr,
   output logic [DATA_W-1:0] instr_read,
   output logic              instr_valid,
   input  logic              data_req,
   input  logic              data_we,
   input  logic [3:0]        data_be,
   input  logic [ADR_W-1:0]  data_adr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_valid,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADR_W-1:0]  mem_adr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              err
);

   state_t r_state, w_state_nxt;
   logic   r_last, w_last_nxt;
   logic   r_mem_req, w_mem_req_nxt;
   logic   r_mem_we, w_mem_we_nxt;
   logic [3:0] r_mem_be, w_mem_be_nxt;
   logic   r_ivalid, w_ivalid_nxt;
   logic   r_dvalid, w_dvalid_nxt;
   logic   r_err, w_err_nxt;

   logic   w_grant;
   logic   w_gnt_data;
   logic   w_ird_en;
   logic   w_drd_en;
   logic   w_tmo;
   logic [ADR_W-1:0]  w_adr_d;
   logic [DATA_W-1:0] w_rd_val;

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   logic [7:0] r_tmo_cnt;

   // Idle and response cycles hold the counter at zero, so it restarts on every grant.
   always_ff @(posedge CLK) begin
      if (RES || r_state == IDLE || r_state == RESP)
         r_tmo_cnt <= '0;
      else
         r_tmo_cnt <= r_tmo_cnt + 8'd1;
   end

   assign w_tmo = (r_tmo_cnt == TMO_LAST);
`else
   logic w_unused_cfg;
   assign w_unused_cfg = (TIMEOUT != 0);
   assign w_tmo        = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RES) begin
         r_state   <= IDLE;
         r_last    <= GNT_INSTR;
         r_mem_req <= 1'b0;
         r_mem_we  <= 1'b0;
         r_mem_be  <= 4'h0;
         r_ivalid  <= 1'b0;
         r_dvalid  <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_last    <= w_last_nxt;
         r_mem_req <= w_mem_req_nxt;
         r_mem_we  <= w_mem_we_nxt;
         r_mem_be  <= w_mem_be_nxt;
         r_ivalid  <= w_ivalid_nxt;
         r_dvalid  <= w_dvalid_nxt;
         r_err     <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_last_nxt    = r_last;
      w_mem_req_nxt = r_mem_req;
      w_mem_we_nxt  = r_mem_we;
      w_mem_be_nxt  = r_mem_be;
      w_ivalid_nxt  = 1'b0;
      w_dvalid_nxt  = 1'b0;
      w_err_nxt     = 1'b0;
      w_grant       = 1'b0;
      w_gnt_data    = 1'b0;
      w_ird_en      = 1'b0;
      w_drd_en      = 1'b0;
      w_rd_val      = mem_rdata;
      unique case (r_state)
         IDLE: begin
            if (instr_req || data_req) begin
               w_grant    = 1'b1;
               w_gnt_data = data_req &&
                            (!instr_req || r_last == GNT_INSTR);
               w_last_nxt    = w_gnt_data ? GNT_DATA : GNT_INSTR;
               w_state_nxt   = w_gnt_data ? BUSY_D : BUSY_I;
               w_mem_req_nxt = 1'b1;
               w_mem_we_nxt  = w_gnt_data ? data_we : 1'b0;
               w_mem_be_nxt  = w_gnt_data ? data_be : 4'hF;
            end
         end
         BUSY_I, BUSY_D: begin
            // A same-cycle ack wins over an expiring timeout.
            if (mem_ack || w_tmo) begin
               w_state_nxt   = RESP;
               w_mem_req_nxt = 1'b0;
               w_mem_we_nxt  = 1'b0;
               w_err_nxt     = !mem_ack;
               if (!mem_ack || r_mem_we)
                  w_rd_val = '0;
               if (r_state == BUSY_I) begin
                  w_ird_en     = 1'b1;
                  w_ivalid_nxt = 1'b1;
               end else begin
                  w_drd_en     = 1'b1;
                  w_dvalid_nxt = 1'b1;
               end
            end
         end
         RESP: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign w_adr_d = w_gnt_data ? data_adr : instr_adr;

   REG_DRE_32 #(.WIDTH(ADR_W)) u_adr (
      .CLK (CLK),
      .RES (RES),
      .EN  (w_grant),
      .D   (w_adr_d),
      .Q   (mem_adr)
   );

   REG_DRE_32 #(.WIDTH(DATA_W)) u_wdata (
      .CLK (CLK),
      .RES (RES),
      .EN  (w_grant && w_gnt_data),
      .D   (data_wdata),
      .Q   (mem_wdata)
   );

   REG_DRE_32 #(.WIDTH(DATA_W)) u_iread (
      .CLK (CLK),
      .RES (RES),
      .EN  (w_ird_en),
      .D   (w_rd_val),
      .Q   (instr_read)
   );

   REG_DRE_32 #(.WIDTH(DATA_W)) u_dread (
      .CLK (CLK),
      .RES (RES),
      .EN  (w_drd_en),
      .D   (w_rd_val),
      .Q   (data_rdata)
   );

   assign mem_req     = r_mem_req;
   assign mem_we      = r_mem_we;
   assign mem_be      = r_mem_be;
   assign instr_valid = r_ivalid;
   assign data_valid  = r_dvalid;
   assign err         = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks for mem_arbiter against a memory model.
// Timeout checks are compiled in when MEM_TIMEOUT_EN is defined.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          CLK = 1'b0;
   logic          RES;
   logic          instr_req;
   logic [AW-1:0] instr_adr;
   logic [DW-1:0] instr_read;
   logic          instr_valid;
   logic          data_req;
   logic          data_we;
   logic [3:0]    data_be;
   logic [AW-1:0] data_adr;
   logic [DW-1:0] data_wdata;
   logic [DW-1:0] data_rdata;
   logic          data_valid;
   logic          mem_req;
   logic          mem_we;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;
   logic          err;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem     [0:255];
   logic [31:0] ref_mem [0:255];
   int ack_dly    = 1;
   int stray_req  = 0;
   int stray_seen = 0;
   int rcnt       = 0;
   int ridx       = 0;

   always #5 CLK = ~CLK;

   mem_arbiter #(
      .ADR_W  (AW),
      .DATA_W (DW)
`ifdef MEM_TIMEOUT_EN
      , .TIMEOUT (4)
`endif
   ) dut (
      .CLK         (CLK),
      .RES         (RES),
      .instr_req   (instr_req),
      .instr_adr   (instr_adr),
      .instr_read  (instr_read),
      .instr_valid (instr_valid),
      .data_req    (data_req),
      .data_we     (data_we),
      .data_be     (data_be),
      .data_adr    (data_adr),
      .data_wdata  (data_wdata),
      .data_rdata  (data_rdata),
      .data_valid  (data_valid),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_be      (mem_be),
      .mem_adr     (mem_adr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .err         (err)
   );

   // Memory: acks after ack_dly cycles of mem_req; stores return junk.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge CLK);
         mem_ack = 1'b0;
         if (stray_req != stray_seen) begin
            stray_seen = stray_req;
            mem_ack    = 1'b1;
            mem_rdata  = $urandom;
         end else if (mem_req) begin
            rcnt++;
            if (rcnt >= ack_dly) begin
               mem_ack = 1'b1;
               ridx    = int'(mem_adr[9:2]);
               if (mem_we) begin
                  for (int b = 0; b < 4; b++)
                     if (mem_be[b])
                        mem[ridx][8*b +: 8] = mem_wdata[8*b +: 8];
                  mem_rdata = $urandom | 32'h1;
               end else begin
                  mem_rdata = mem[ridx];
               end
            end
         end else begin
            rcnt = 0;
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input int lim, output int who);
      who = -1;
      for (int i = 0; i < lim; i++) begin
         step();
         if (instr_valid) begin
            who = 0;
            break;
         end
         if (data_valid) begin
            who = 1;
            break;
         end
      end
      total++;
      assert (who >= 0) else begin
         bad++;
         $error("FAIL wait_valid observed=none expected=valid within %0d", lim);
      end
   endtask

   initial begin
      int who;
      int exp_ord [5];
      int ipend, dpend, igap, dgap, must_next, stall, ndone;
      logic [31:0] ia, da, dw;
      logic [3:0]  dbe;
      logic        dwe;
      int ix;

      exp_ord = '{1, 0, 1, 0, 1};
      for (int i = 0; i < 256; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      RES        = 1'b1;
      instr_req  = 1'b0;
      instr_adr  = '0;
      data_req   = 1'b0;
      data_we    = 1'b0;
      data_be    = 4'h0;
      data_adr   = '0;
      data_wdata = '0;
      step();
      step();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_be", mem_be, 0);
      chk("rst_mem_adr", mem_adr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_ivalid", instr_valid, 0);
      chk("rst_dvalid", data_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_iread", instr_read, 0);
      chk("rst_drdata", data_rdata, 0);
      RES = 1'b0;
      step();

      // single fetch
      mem[16]   = 32'h00500093;
      ack_dly   = 1;
      instr_req = 1'b1;
      instr_adr = 32'h40;
      step();
      chk("f_mem_req", mem_req, 1);
      chk("f_mem_adr", mem_adr, 32'h40);
      chk("f_mem_we", mem_we, 0);
      chk("f_mem_be", mem_be, 4'hF);
      chk("f_ivalid_early", instr_valid, 0);
      step();
      chk("f_ivalid", instr_valid, 1);
      chk("f_iread", instr_read, 32'h00500093);
      chk("f_dvalid", data_valid, 0);
      chk("f_err", err, 0);
      chk("f_mem_req_drop", mem_req, 0);
      instr_req = 1'b0;
      step();
      chk("f_ivalid_pulse", instr_valid, 0);
      chk("f_iread_hold", instr_read, 32'h00500093);

      // store with ack in third busy cycle
      ack_dly    = 3;
      data_req   = 1'b1;
      data_we    = 1'b1;
      data_be    = 4'b0011;
      data_adr   = 32'h100;
      data_wdata = 32'hDEADBEEF;
      step();
      chk("s_mem_req", mem_req, 1);
      chk("s_mem_adr", mem_adr, 32'h100);
      chk("s_mem_we", mem_we, 1);
      chk("s_mem_be", mem_be, 4'b0011);
      chk("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("s_hold_req", mem_req, 1);
         chk("s_hold_adr", mem_adr, 32'h100);
         chk("s_hold_we", mem_we, 1);
         chk("s_hold_be", mem_be, 4'b0011);
         chk("s_hold_wdata", mem_wdata, 32'hDEADBEEF);
         chk("s_dvalid_early", data_valid, 0);
      end
      step();
      chk("s_dvalid", data_valid, 1);
      chk("s_drdata", data_rdata, 0);
      chk("s_mem_req_drop", mem_req, 0);
      chk("s_mem_we_drop", mem_we, 0);
      chk("s_ivalid", instr_valid, 0);
      data_req = 1'b0;
      step();
      chk("s_dvalid_pulse", data_valid, 0);

      // load back the partially written word
      ack_dly  = 2;
      data_we  = 1'b0;
      data_adr = 32'h100;
      data_req = 1'b1;
      wait_valid(20, who);
      chk("l_port", who, 1);
      chk("l_data", data_rdata, 32'h0000BEEF);
      data_req = 1'b0;
      step();

      // tie fairness from reset
      ack_dly   = 1;
      RES       = 1'b1;
      instr_req = 1'b1;
      instr_adr = 32'h40;
      data_req  = 1'b1;
      data_we   = 1'b0;
      data_adr  = 32'h100;
      step();
      RES = 1'b0;
      for (int n = 0; n < 2; n++) begin
         wait_valid(20, who);
         chk("tie_order", who, exp_ord[n]);
         if (who == 0) instr_req = 1'b0;
         if (who == 1) data_req = 1'b0;
      end
      step();
      instr_req = 1'b1;
      data_req  = 1'b1;
      for (int n = 2; n < 5; n++) begin
         wait_valid(20, who);
         chk("tie_order2", who, exp_ord[n]);
         if (who == 0) instr_req = 1'b0;
         if (who == 1) data_req = 1'b0;
         step();
         if (n == 2 && who == 1) data_req = 1'b1;
      end

      // stray ack in idle
      instr_req = 1'b0;
      data_req  = 1'b0;
      step();
      stray_req++;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stray_ivalid", instr_valid, 0);
         chk("stray_dvalid", data_valid, 0);
         chk("stray_mem_req", mem_req, 0);
      end

      // reset while busy on the data port
      ack_dly  = 1000;
      data_req = 1'b1;
      data_we  = 1'b0;
      data_adr = 32'h100;
      step();
      chk("rb_mem_req", mem_req, 1);
      step();
      chk("rb_mem_req_hold", mem_req, 1);
      RES = 1'b1;
      step();
      chk("rb_mem_req_drop", mem_req, 0);
      chk("rb_dvalid", data_valid, 0);
      RES      = 1'b0;
      data_req = 1'b0;
      stray_req++;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rb_late_dvalid", data_valid, 0);
         chk("rb_late_ivalid", instr_valid, 0);
         chk("rb_late_mem_req", mem_req, 0);
      end

`ifdef MEM_TIMEOUT_EN
      // fetch with no ack aborts after four busy cycles
      ack_dly   = 1000;
      instr_req = 1'b1;
      instr_adr = 32'h40;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("to_mem_req", mem_req, 1);
         chk("to_ivalid_early", instr_valid, 0);
      end
      step();
      chk("to_mem_req_drop", mem_req, 0);
      chk("to_ivalid", instr_valid, 1);
      chk("to_err", err, 1);
      chk("to_iread", instr_read, 0);
      instr_req = 1'b0;
      step();
      chk("to_err_pulse", err, 0);
      // ack on the expiry cycle is a success
      ack_dly   = 4;
      instr_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("ta_mem_req", mem_req, 1);
      end
      step();
      chk("ta_ivalid", instr_valid, 1);
      chk("ta_err", err, 0);
      chk("ta_iread", instr_read, 32'h00500093);
      instr_req = 1'b0;
      step();
`endif

      // randomized traffic against the reference memory
      ack_dly   = 1;
      ipend     = 0;
      dpend     = 0;
      igap      = 0;
      dgap      = 0;
      must_next = -1;
      stall     = 0;
      ndone     = 0;
      ia = '0; da = '0; dw = '0; dbe = '0; dwe = 1'b0;
      for (int c = 0; c < 6000 && ndone < 300; c++) begin
         int done_i, done_d;
         done_i = 0;
         done_d = 0;
         step();
         if (instr_valid || data_valid) begin
            who = data_valid ? 1 : 0;
            chk("rnd_one_valid", instr_valid & data_valid, 0);
            chk("rnd_err", err, 0);
            chk("rnd_pending", (who == 1) ? dpend : ipend, 1);
            if (must_next >= 0)
               chk("rnd_fair", who, must_next);
            if (who == 0) begin
               ix = int'(ia[9:2]);
               chk("rnd_iread", instr_read, ref_mem[ix]);
               ipend     = 0;
               instr_req = 1'b0;
               igap      = $urandom_range(0, 3);
               done_i    = 1;
               must_next = dpend ? 1 : -1;
            end else begin
               ix = int'(da[9:2]);
               if (dwe) begin
                  for (int b = 0; b < 4; b++)
                     if (dbe[b]) ref_mem[ix][8*b +: 8] = dw[8*b +: 8];
                  chk("rnd_store_rd", data_rdata, 0);
               end else begin
                  chk("rnd_load", data_rdata, ref_mem[ix]);
               end
               dpend     = 0;
               data_req  = 1'b0;
               dgap      = $urandom_range(0, 3);
               done_d    = 1;
               must_next = ipend ? 0 : -1;
            end
            ack_dly = $urandom_range(1, 3);
            ndone++;
            stall = 0;
         end else begin
            stall++;
            if (stall > 40) begin
               chk("rnd_stall", stall, 0);
               break;
            end
         end
         if (ipend == 0 && done_i == 0) begin
            if (igap > 0) igap--;
            else if ($urandom_range(0, 1) == 1) begin
               ipend     = 1;
               ia        = 32'h200 + {$urandom_range(0, 15), 2'b00};
               instr_adr = ia;
               instr_req = 1'b1;
            end
         end
         if (dpend == 0 && done_d == 0) begin
            if (dgap > 0) dgap--;
            else if ($urandom_range(0, 1) == 1) begin
               dpend      = 1;
               da         = 32'h200 + {$urandom_range(0, 15), 2'b00};
               dwe        = 1'($urandom_range(0, 1));
               dbe        = 4'($urandom_range(1, 15));
               dw         = $urandom;
               data_adr   = da;
               data_we    = dwe;
               data_be    = dbe;
               data_wdata = dw;
               data_req   = 1'b1;
            end
         end
      end
      chk("rnd_done", ndone >= 300, 1);
      instr_req = 1'b0;
      data_req  = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
